// File: rtl/lif_pe_array_pkg.sv
// Shared types and arithmetic helpers for the leaky integrate-and-fire neuron array.
package lif_pe_array_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FIRE = 1'b1
    } pe_state_t;

    // Signed add clamped to the representable range of a width-bit two's complement value.
    function automatic int sat_add(input int v, input int w, input int width);
        int sum;
        int hi;
        int lo;
        sum = v + w;
        hi  = (1 << (width - 1)) - 1;
        lo  = -(1 << (width - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

    function automatic int leak(input int v, input int shift);
        if (shift == 0) begin
            return v;
        end
        return v - (v >>> shift);
    endfunction

endpackage

// File: rtl/lif_pe_array_if.sv
// Spike-event, timestep and configuration bus between the router side and the neuron array.
interface lif_pe_array_if #(
    parameter int N_NEURONS = 4,
    parameter int FAN_IN    = 16,
    parameter int W_WIDTH   = 8,
    parameter int V_WIDTH   = 12
);
    localparam int AW = (FAN_IN > 1) ? $clog2(FAN_IN) : 1;
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                      weight_w_en;
    logic [AW-1:0]             weight_addr;
    logic [NW-1:0]             weight_nrn;
    logic signed [W_WIDTH-1:0] weight_in;
    logic                      memb_pot_w_en;
    logic signed [V_WIDTH-1:0] memb_pot_in;
    logic signed [V_WIDTH-1:0] memb_pot_rd;
    logic                      in_valid;
    logic [AW-1:0]             in_idx;
    logic                      in_ready;
    logic                      step_valid;
    logic                      step_ready;
    logic [N_NEURONS-1:0]      spike;
    logic                      spike_valid;

    modport master (
        output weight_w_en, weight_addr, weight_nrn, weight_in,
        output memb_pot_w_en, memb_pot_in, in_valid, in_idx, step_valid,
        input  memb_pot_rd, in_ready, step_ready, spike, spike_valid
    );

    modport slave (
        input  weight_w_en, weight_addr, weight_nrn, weight_in,
        input  memb_pot_w_en, memb_pot_in, in_valid, in_idx, step_valid,
        output memb_pot_rd, in_ready, step_ready, spike, spike_valid
    );

endinterface

// File: rtl/lif_pe_array_neuron.sv
// One LIF neuron: membrane potential, refractory counter and accumulate/fire/leak update.
module lif_pe_array_neuron
    import lif_pe_array_pkg::*;
#(
    parameter int W_WIDTH    = 8,
    parameter int V_WIDTH    = 12,
    parameter int THRESHOLD  = 20,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      acc_en_i,
    input  logic signed [W_WIDTH-1:0] weight_i,
    input  logic                      wr_en_i,
    input  logic signed [V_WIDTH-1:0] wr_val_i,
    input  logic                      fire_en_i,
    output logic signed [V_WIDTH-1:0] v_o,
    output logic                      fire_o
);
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic signed [V_WIDTH-1:0] v_q, v_d;
    logic [RW-1:0]             refr_q, refr_d;
    logic                      refr_idle;

    assign refr_idle = (refr_q == '0);
    assign fire_o    = fire_en_i && refr_idle && (int'(v_q) > THRESHOLD);
    assign v_o       = v_q;

    // Timestep update takes precedence; host overwrite beats a same-cycle accumulation.
    always_comb begin
        v_d    = v_q;
        refr_d = refr_q;
        if (fire_en_i) begin
            if (fire_o) begin
                v_d    = '0;
                refr_d = RW'(REFRACT);
            end else begin
                v_d = V_WIDTH'(leak(int'(v_q), LEAK_SHIFT));
                if (!refr_idle) begin
                    refr_d = refr_q - RW'(1);
                end
            end
        end else if (wr_en_i) begin
            v_d = wr_val_i;
        end else if (acc_en_i && refr_idle) begin
            v_d = V_WIDTH'(sat_add(int'(v_q), int'(weight_i), V_WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            refr_q <= '0;
        end else begin
            v_q    <= v_d;
            refr_q <= refr_d;
        end
    end

endmodule

// File: rtl/lif_pe_array.sv
// Array of LIF neurons sharing one input spike bus, with weight storage and timestep FSM.
module lif_pe_array
    import lif_pe_array_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int FAN_IN     = 16,
    parameter int W_WIDTH    = 8,
    parameter int V_WIDTH    = 12,
    parameter int THRESHOLD  = 20,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2
) (
    input  logic          clock,
    input  logic          reset,
    lif_pe_array_if.slave bus
);
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    pe_state_t                 state_q;
    logic signed [W_WIDTH-1:0] weight_q [FAN_IN][N_NEURONS];
    logic [N_NEURONS-1:0]      spike_q;
    logic                      spike_valid_q;
    logic [N_NEURONS-1:0]      fire;
    logic signed [V_WIDTH-1:0] v [N_NEURONS];
    logic                      in_accept;
    logic                      step_accept;
    logic                      in_idle;

    assign in_idle        = (state_q == IDLE);
    assign bus.in_ready   = in_idle;
    assign bus.step_ready = in_idle && !bus.in_valid;
    assign in_accept      = bus.in_valid && in_idle;
    assign step_accept    = bus.step_valid && bus.step_ready;
    assign bus.spike       = spike_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.memb_pot_rd = v[bus.weight_nrn];

    // Weight writes land at the edge, so a same-cycle event still sees the old weight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            for (int a = 0; a < FAN_IN; a++) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    weight_q[a][n] <= '0;
                end
            end
        end else begin
            if (bus.weight_w_en) begin
                weight_q[bus.weight_addr][bus.weight_nrn] <= bus.weight_in;
            end
            spike_valid_q <= (state_q == FIRE);
            case (state_q)
                IDLE: begin
                    if (step_accept) begin
                        state_q <= FIRE;
                    end
                end
                FIRE: begin
                    spike_q <= fire;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_nrn
        lif_pe_array_neuron #(
            .W_WIDTH   (W_WIDTH),
            .V_WIDTH   (V_WIDTH),
            .THRESHOLD (THRESHOLD),
            .LEAK_SHIFT(LEAK_SHIFT),
            .REFRACT   (REFRACT)
        ) u_nrn (
            .clk      (clock),
            .rst      (reset),
            .acc_en_i (in_accept),
            .weight_i (weight_q[bus.in_idx][gi]),
            .wr_en_i  (in_idle && bus.memb_pot_w_en && (bus.weight_nrn == NW'(gi))),
            .wr_val_i (bus.memb_pot_in),
            .fire_en_i(state_q == FIRE),
            .v_o      (v[gi]),
            .fire_o   (fire[gi])
        );
    end

endmodule

// File: tb/tb_lif_pe_array.sv
// Directed bench for lif_pe_array: spike vectors go through a queue scoreboard, potentials are read back directly.
module tb_lif_pe_array;
    localparam int N  = 4;
    localparam int FI = 16;
    localparam int WW = 8;
    localparam int VW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lif_pe_array_if #(.N_NEURONS(N), .FAN_IN(FI), .W_WIDTH(WW), .V_WIDTH(VW)) bus ();

    lif_pe_array #(
        .N_NEURONS(N), .FAN_IN(FI), .W_WIDTH(WW), .V_WIDTH(VW),
        .THRESHOLD(20), .LEAK_SHIFT(3), .REFRACT(2)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [N-1:0] exp_q [$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_weight(input int a, input int n, input int w);
        bus.weight_w_en = 1'b1;
        bus.weight_addr = 4'(a);
        bus.weight_nrn  = 2'(n);
        bus.weight_in   = WW'(w);
        tick();
        bus.weight_w_en = 1'b0;
    endtask

    task automatic wr_pot(input int n, input int v);
        bus.memb_pot_w_en = 1'b1;
        bus.weight_nrn    = 2'(n);
        bus.memb_pot_in   = VW'(v);
        tick();
        bus.memb_pot_w_en = 1'b0;
    endtask

    task automatic check_pot(input string tag, input int n, input int exp);
        bus.weight_nrn = 2'(n);
        #1;
        check(tag, bus.memb_pot_rd, exp);
    endtask

    task automatic send_event(input int idx);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_idx   = 4'(idx);
        while (!bus.in_ready && k < 10) begin
            tick();
            k++;
        end
        if (k == 10) check("in_ready_timeout", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic await_spike();
        int k;
        logic [N-1:0] exp_v;
        k = 0;
        while (!bus.spike_valid && k < 8) begin
            tick();
            k++;
        end
        check("spike_latency", k, 1);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("spike_vec", bus.spike, exp_v);
        end
        tick();
        check("spike_valid_pulse", bus.spike_valid, 0);
    endtask

    task automatic do_step(input logic [N-1:0] exp_v);
        int k;
        k = 0;
        exp_q.push_back(exp_v);
        bus.step_valid = 1'b1;
        #1;
        while (!bus.step_ready && k < 10) begin
            tick();
            k++;
        end
        if (k == 10) check("step_ready_timeout", bus.step_ready, 1);
        tick();
        bus.step_valid = 1'b0;
        await_spike();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.weight_w_en   = 1'b0;
        bus.weight_addr   = '0;
        bus.weight_nrn    = '0;
        bus.weight_in     = '0;
        bus.memb_pot_w_en = 1'b0;
        bus.memb_pot_in   = '0;
        bus.in_valid      = 1'b0;
        bus.in_idx        = '0;
        bus.step_valid    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_spike", bus.spike, 0);
        check("rst_spike_valid", bus.spike_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        for (int n = 0; n < N; n++) check_pot("rst_pot", n, 0);

        // Fire: 3 x 7 = 21 > 20
        wr_weight(0, 0, 7);
        for (int i = 0; i < 3; i++) send_event(0);
        check_pot("fire_acc_v0", 0, 21);
        do_step(4'b0001);
        check_pot("fire_reset_v0", 0, 0);

        // Refractory: two steps ignore input, then accumulation resumes
        for (int s = 0; s < 2; s++) begin
            send_event(0);
            send_event(0);
            check_pot("refr_hold_v0", 0, 0);
            do_step(4'b0000);
        end
        send_event(0);
        send_event(0);
        check_pot("refr_resume_v0", 0, 14);
        do_step(4'b0000);
        check_pot("leak_v0_14", 0, 13);

        // Leak
        wr_pot(1, 16);
        do_step(4'b0000);
        check_pot("leak_pos", 1, 14);
        wr_pot(1, -16);
        do_step(4'b0000);
        check_pot("leak_neg", 1, -14);
        wr_pot(1, -1);
        do_step(4'b0000);
        check_pot("leak_m1", 1, 0);

        // Saturation at both rails
        wr_weight(1, 2, 127);
        wr_pot(2, 2040);
        send_event(1);
        check_pot("sat_pos", 2, 2047);
        wr_weight(1, 2, -128);
        wr_pot(2, -2040);
        send_event(1);
        check_pot("sat_neg", 2, -2048);
        wr_pot(2, 0);

        // Same-cycle weight write and event: old weight used
        wr_pot(0, 0);
        bus.weight_w_en = 1'b1;
        bus.weight_addr = 4'd3;
        bus.weight_nrn  = 2'd0;
        bus.weight_in   = 8'sd5;
        bus.in_valid    = 1'b1;
        bus.in_idx      = 4'd3;
        tick();
        bus.weight_w_en = 1'b0;
        bus.in_valid    = 1'b0;
        check_pot("old_weight", 0, 0);
        send_event(3);
        check_pot("new_weight", 0, 5);

        // Potential write beats same-cycle accumulation
        bus.memb_pot_w_en = 1'b1;
        bus.weight_nrn    = 2'd0;
        bus.memb_pot_in   = 12'sd100;
        bus.in_valid      = 1'b1;
        bus.in_idx        = 4'd3;
        tick();
        bus.memb_pot_w_en = 1'b0;
        bus.in_valid      = 1'b0;
        check_pot("pot_wr_wins", 0, 100);

        // Collision: event wins, step follows and sees the event
        for (int n = 0; n < N; n++) wr_pot(n, 0);
        wr_weight(2, 3, 25);
        bus.in_valid   = 1'b1;
        bus.in_idx     = 4'd2;
        bus.step_valid = 1'b1;
        #1;
        check("coll_step_ready", bus.step_ready, 0);
        check("coll_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("coll_step_ready2", bus.step_ready, 1);
        exp_q.push_back(4'b1000);
        tick();
        bus.step_valid = 1'b0;
        await_spike();
        check_pot("coll_v3", 3, 0);

        // Reset during FIRE drops the pending step
        wr_pot(1, 50);
        bus.step_valid = 1'b1;
        tick();
        bus.step_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_spike", bus.spike, 0);
        check("mid_rst_spike_valid", bus.spike_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        tick();
        rst = 1'b0;
        for (int n = 0; n < N; n++) check_pot("mid_rst_pot", n, 0);
        tick();
        check("mid_rst_no_spike", bus.spike_valid, 0);
        send_event(0);
        check_pot("mid_rst_weight0", 0, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
